axilite_slave: RTL and testbench
================================

# axilite_slave

AXI4-Lite slave endpoint that terminates the no-B-channel AXI-Lite link driven by `axilite_master`. It converts each accepted write (AW then W) into a single-pulse backend write request and each accepted read (AR) into a single-pulse backend read request. It returns read data on R. The backend protocol is the same start/done pulse protocol the master exposes on its own backend side, so a register file or bridge can attach directly.

## Interface
- `ADDR_WIDTH`, default 12, is the width of AXI and backend addresses.
- `DATA_WIDTH`, default 32, is the data width. It must be 32, so the strobe is 4 bits.
- `TIMEOUT_CYCLES`, default 255, is the backend wait limit. It is used only with `AXILITE_SLAVE_TIMEOUT_EN`. Range is 1..65535.
- `axi_aclk` in 1: the single clock.
- `axi_aresetn` in 1: reset, asynchronous, active-low.
- `axi_awvalid` in 1, `axi_awaddr` in ADDR_WIDTH, `axi_awready` out 1: write address channel.
- `axi_wvalid` in 1, `axi_wdata` in 32, `axi_wstrb` in 4, `axi_wready` out 1: write data channel.
- `axi_arvalid` in 1, `axi_araddr` in ADDR_WIDTH, `axi_arready` out 1: read address channel.
- `axi_rvalid` out 1, `axi_rdata` out 32, `axi_rready` in 1: read data channel.
- `bk_wstart` out 1, `bk_waddr` out ADDR_WIDTH, `bk_wdata` out 32, `bk_wstrb` out 4, `bk_wdone` in 1: backend write request.
- `bk_rstart` out 1, `bk_raddr` out ADDR_WIDTH, `bk_rdata` in 32, `bk_rdone` in 1: backend read request.
- `timeout_err` out 1: sticky backend-timeout flag. It is tied to 0 when the timeout feature is compiled out.

## Operation
- The write FSM and read FSM are independent and run concurrently. Both `bk_wstart` and `bk_rstart` may pulse in the same cycle.
- **Write FSM:**
  - `W_ADDR` (awready=1): on awvalid&awready, capture awaddr and go to `W_DATA`.
  - `W_DATA` (wready=1): on wvalid&wready, capture wdata/wstrb and go to `W_REQ`.
  - `W_REQ`: drive bk_wstart=1 for exactly one cycle, then go to `W_WAIT`.
  - `W_WAIT`: on bk_wdone, go to `W_ADDR`.
- **Write ordering:** AW must precede W. The slave never accepts W before AW.
- **Read FSM:**
  - `R_ADDR` (arready=1): on arvalid&arready, capture araddr and go to `R_REQ`.
  - `R_REQ`: drive bk_rstart=1 for one cycle, then go to `R_WAIT`.
  - `R_WAIT`: on bk_rdone, register bk_rdata into axi_rdata and go to `R_DATA`.
  - `R_DATA` (rvalid=1): on rvalid&rready, go to `R_ADDR`.
- **Backend outputs:** bk_waddr/bk_wdata/bk_wstrb/bk_raddr come from registers. They are stable from the start pulse until the FSM returns to idle.
- **Ignored inputs:** bk_wdone outside `W_WAIT` and bk_rdone outside `R_WAIT` are ignored.
- **Done in the start cycle:** a done pulse in the same cycle as its start is ignored. Done is sampled from the cycle after start onward.
- **Valid deasserted mid-wait:** awvalid/wvalid/arvalid deasserting while the slave waits has no effect. Ready stays high until a handshake occurs.
- **Data hold:** axi_rdata holds its value after R completes until the next bk_rdone capture.

## Timing
- **Reset values:** every output is 0 while reset is asserted, including awready, wready, arready, rvalid, rdata, all bk_* outputs and timeout_err. Both FSMs reset to idle.
- **Ready flags after reset:** awready and arready are registered. They rise on the first clock edge after reset release.
- **Reset mid-operation:** asynchronous reset in any state aborts the transaction immediately. No start pulse and no rvalid is emitted afterwards for the aborted transaction.
- **Write latency:**
  - AW handshake at cycle T.
  - wready is high from T+1, so the earliest W handshake is T+1.
  - bk_wstart is high in the cycle after the W handshake.
  - The FSM returns to idle, with awready high again, the cycle after bk_wdone.
  - Minimum write occupancy is 4 cycles.
- **Read latency:**
  - AR handshake at T.
  - bk_rstart is high at T+1.
  - With bk_rdone at cycle D ≥ T+2, rvalid and rdata are valid at D+1.
  - arready is high again the cycle after the R handshake.
- **Outstanding transactions:** at most one outstanding write and one outstanding read.

## Configuration
- `AXILITE_SLAVE_TIMEOUT_EN` defined:
  - A 16-bit counter runs in `W_WAIT` and `R_WAIT`, starting from 0 at entry.
  - When it reaches TIMEOUT_CYCLES without the matching done, the write FSM returns to idle.
  - On a read timeout, the read FSM goes to `R_DATA` with rdata = 32'hDEAD_BEEF.
  - timeout_err is set and stays set until reset.
  - A done arriving in the same cycle as the timeout takes priority; the timeout does not fire.
- Macro undefined:
  - There is no counter, and the slave waits forever for done.
  - timeout_err is constant 0.

## Test plan
- **Basic write:** AW addr 0x010, W data 0xA5A5_1234, strb 0xF; backend returns bk_wdone 3 cycles after start. Required: exactly one bk_wstart pulse with bk_waddr=0x010 and bk_wdata=0xA5A5_1234; awready high again the cycle after done.
- **Basic read:** AR addr 0x024; backend returns bk_rdone with bk_rdata=0x0000_BEEF 2 cycles after bk_rstart. Required: rvalid with rdata=0x0000_BEEF the cycle after done; rready held low for 4 cycles keeps rvalid and rdata stable.
- **Concurrent write and read:** issued in the same cycle to addresses 0x004 and 0x008. Required: both start pulses occur; both complete independently; no cross-contamination of address or data.
- **Ordering and stray done:** wvalid asserted before awvalid leaves wready low until AW completes; a stray bk_wdone in `W_ADDR` causes no state change.
- **Reset mid-operation:** axi_aresetn pulsed low while in `R_WAIT`. Required: all outputs 0 immediately; no rvalid after release; a next read to 0x030 works normally.
- **Timeout (macro on, TIMEOUT_CYCLES=8):** read with no bk_rdone. Required: rdata=0xDEAD_BEEF, rvalid asserted, timeout_err=1 and sticky; with the macro off, the FSM remains in `R_WAIT` for over 1000 cycles.

Source files
------------

// File: rtl/axilite_slave.sv
// AXI4-Lite slave endpoint (no B channel). Converts AW+W into one backend
// write start pulse and AR into one backend read start pulse, returning read
// data on R. Write and read paths are independent FSMs.
// Optional backend timeout: define AXILITE_SLAVE_TIMEOUT_EN.
module axilite_slave #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      axi_aclk,
   input  logic                      axi_aresetn,
   input  logic                      axi_awvalid,
   input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
   output logic                      axi_awready,
   input  logic                      axi_wvalid,
   input  logic [DATA_WIDTH-1:0]     axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
   output logic                      axi_wready,
   input  logic                      axi_arvalid,
   input  logic [ADDR_WIDTH-1:0]     axi_araddr,
   output logic                      axi_arready,
   output logic                      axi_rvalid,
   output logic [DATA_WIDTH-1:0]     axi_rdata,
   input  logic                      axi_rready,
   output logic                      bk_wstart,
   output logic [ADDR_WIDTH-1:0]     bk_waddr,
   output logic [DATA_WIDTH-1:0]     bk_wdata,
   output logic [DATA_WIDTH/8-1:0]   bk_wstrb,
   input  logic                      bk_wdone,
   output logic                      bk_rstart,
   output logic [ADDR_WIDTH-1:0]     bk_raddr,
   input  logic [DATA_WIDTH-1:0]     bk_rdata,
   input  logic                      bk_rdone,
   output logic                      timeout_err
);

   // state    | meaning
   // W_ADDR   | idle, awready high, waiting for AW
   // W_DATA   | address held, wready high, waiting for W
   // W_REQ    | bk_wstart pulse cycle
   // W_WAIT   | waiting for bk_wdone (or timeout)
   // R_ADDR   | idle, arready high, waiting for AR
   // R_REQ    | bk_rstart pulse cycle
   // R_WAIT   | waiting for bk_rdone (or timeout)
   // R_DATA   | rvalid high until R handshake
   typedef enum logic [1:0] {W_ADDR, W_DATA, W_REQ, W_WAIT} w_state_t;
   typedef enum logic [1:0] {R_ADDR, R_REQ, R_WAIT, R_DATA} r_state_t;

   if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("axilite_slave: DATA_WIDTH must be 32 and TIMEOUT_CYCLES in 1..65535");
   end

   w_state_t                  w_state_q, w_state_d;
   r_state_t                  r_state_q, r_state_d;
   logic                      awready_q, awready_d;
   logic                      wready_q, wready_d;
   logic                      arready_q, arready_d;
   logic                      rvalid_q, rvalid_d;
   logic                      bk_wstart_q, bk_wstart_d;
   logic                      bk_rstart_q, bk_rstart_d;
   logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
   logic [ADDR_WIDTH-1:0]     raddr_q, raddr_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic                      w_timeout;
   logic                      r_timeout;

`ifdef AXILITE_SLAVE_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] w_cnt_q, w_cnt_d;
   logic [15:0] r_cnt_q, r_cnt_d;
   logic        timeout_err_q, timeout_err_d;

   // A done arriving in the limit cycle wins, so timeouts are qualified by !done.
   assign w_timeout = (w_state_q == W_WAIT) && !bk_wdone && (w_cnt_q == TIMEOUT_LIMIT);
   assign r_timeout = (r_state_q == R_WAIT) && !bk_rdone && (r_cnt_q == TIMEOUT_LIMIT);

   // Wait counters restart from zero each time a wait state is entered.
   always_comb begin
      w_cnt_d       = (w_state_q == W_WAIT) ? w_cnt_q + 16'd1 : 16'd0;
      r_cnt_d       = (r_state_q == R_WAIT) ? r_cnt_q + 16'd1 : 16'd0;
      timeout_err_d = timeout_err_q | w_timeout | r_timeout;
   end

   // Timeout counters and sticky error flag.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         w_cnt_q       <= '0;
         r_cnt_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         w_cnt_q       <= w_cnt_d;
         r_cnt_q       <= r_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign w_timeout   = 1'b0;
   assign r_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Write FSM next state; channel flags are decoded from the next state so
   // they are registered yet line up with the state they belong to.
   always_comb begin
      w_state_d = w_state_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      case (w_state_q)
         W_ADDR: if (axi_awvalid && awready_q) begin
            waddr_d   = axi_awaddr;
            w_state_d = W_DATA;
         end
         W_DATA: if (axi_wvalid && wready_q) begin
            wdata_d   = axi_wdata;
            wstrb_d   = axi_wstrb;
            w_state_d = W_REQ;
         end
         W_REQ:  w_state_d = W_WAIT;
         W_WAIT: if (bk_wdone || w_timeout) w_state_d = W_ADDR;
         default: w_state_d = W_ADDR;
      endcase
      awready_d   = (w_state_d == W_ADDR);
      wready_d    = (w_state_d == W_DATA);
      bk_wstart_d = (w_state_d == W_REQ);
   end

   // Read FSM next state, read data capture and registered channel flags.
   always_comb begin
      r_state_d = r_state_q;
      raddr_d   = raddr_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_ADDR: if (axi_arvalid && arready_q) begin
            raddr_d   = axi_araddr;
            r_state_d = R_REQ;
         end
         R_REQ:  r_state_d = R_WAIT;
         R_WAIT: if (bk_rdone) begin
            rdata_d   = bk_rdata;
            r_state_d = R_DATA;
         end else if (r_timeout) begin
            rdata_d   = DATA_WIDTH'(32'hDEAD_BEEF);
            r_state_d = R_DATA;
         end
         R_DATA: if (axi_rready && rvalid_q) r_state_d = R_ADDR;
         default: r_state_d = R_ADDR;
      endcase
      arready_d   = (r_state_d == R_ADDR);
      rvalid_d    = (r_state_d == R_DATA);
      bk_rstart_d = (r_state_d == R_REQ);
   end

   // Write path registers.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         w_state_q   <= W_ADDR;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bk_wstart_q <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
      end else begin
         w_state_q   <= w_state_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bk_wstart_q <= bk_wstart_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
      end
   end

   // Read path registers.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state_q   <= R_ADDR;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         bk_rstart_q <= 1'b0;
         raddr_q     <= '0;
         rdata_q     <= '0;
      end else begin
         r_state_q   <= r_state_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         bk_rstart_q <= bk_rstart_d;
         raddr_q     <= raddr_d;
         rdata_q     <= rdata_d;
      end
   end

   assign axi_awready = awready_q;
   assign axi_wready  = wready_q;
   assign axi_arready = arready_q;
   assign axi_rvalid  = rvalid_q;
   assign axi_rdata   = rdata_q;
   assign bk_wstart   = bk_wstart_q;
   assign bk_waddr    = waddr_q;
   assign bk_wdata    = wdata_q;
   assign bk_wstrb    = wstrb_q;
   assign bk_rstart   = bk_rstart_q;
   assign bk_raddr    = raddr_q;

endmodule

// File: tb/tb_axilite_slave.sv
// Directed testbench for axilite_slave. Inputs are driven and outputs sampled
// 1 ns after the rising edge, so each sample shows the state of that cycle.
module tb_axilite_slave;

   logic        clk;
   logic        rst_n;
   logic        awvalid, wvalid, arvalid, rready;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, arready, rvalid;
   logic [31:0] rdata;
   logic        bk_wstart, bk_wdone, bk_rstart, bk_rdone;
   logic [11:0] bk_waddr, bk_raddr;
   logic [31:0] bk_wdata, bk_rdata;
   logic [3:0]  bk_wstrb;
   logic        timeout_err;

   int n_checks;
   int n_pass;
   int cnt;

   axilite_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rst_n),
      .axi_awvalid (awvalid),
      .axi_awaddr  (awaddr),
      .axi_awready (awready),
      .axi_wvalid  (wvalid),
      .axi_wdata   (wdata),
      .axi_wstrb   (wstrb),
      .axi_wready  (wready),
      .axi_arvalid (arvalid),
      .axi_araddr  (araddr),
      .axi_arready (arready),
      .axi_rvalid  (rvalid),
      .axi_rdata   (rdata),
      .axi_rready  (rready),
      .bk_wstart   (bk_wstart),
      .bk_waddr    (bk_waddr),
      .bk_wdata    (bk_wdata),
      .bk_wstrb    (bk_wstrb),
      .bk_wdone    (bk_wdone),
      .bk_rstart   (bk_rstart),
      .bk_raddr    (bk_raddr),
      .bk_rdata    (bk_rdata),
      .bk_rdone    (bk_rdone),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      awvalid  = 1'b0; awaddr = '0;
      wvalid   = 1'b0; wdata  = '0; wstrb = '0;
      arvalid  = 1'b0; araddr = '0;
      rready   = 1'b0;
      bk_wdone = 1'b0; bk_rdone = 1'b0; bk_rdata = '0;

      // reset values
      #1;
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_outs", {25'd0, wready, rvalid, bk_wstart, bk_rstart, timeout_err, 2'd0}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      check("rel_awready_low", 32'(awready), 32'd0);
      tick();
      check("rel_awready", 32'(awready), 32'd1);
      check("rel_arready", 32'(arready), 32'd1);

      // basic write: AW 0x010, W 0xA5A5_1234, done 3 cycles after start
      awvalid = 1'b1; awaddr = 12'h010;
      tick();
      check("wr_wready", 32'(wready), 32'd1);
      check("wr_awready_low", 32'(awready), 32'd0);
      awvalid = 1'b0;
      wvalid = 1'b1; wdata = 32'hA5A5_1234; wstrb = 4'hF;
      tick();
      wvalid = 1'b0;
      check("wr_waddr", 32'(bk_waddr), 32'h010);
      check("wr_wdata", bk_wdata, 32'hA5A5_1234);
      check("wr_wstrb", 32'(bk_wstrb), 32'hF);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         cnt += int'(bk_wstart);
         if (i == 3) begin
            check("wr_busy_at_done", 32'(awready), 32'd0);
            bk_wdone = 1'b1;
         end
      end
      tick();
      bk_wdone = 1'b0;
      check("wr_one_pulse", 32'(cnt), 32'd1);
      check("wr_idle_after_done", 32'(awready), 32'd1);

      // basic read: AR 0x024, done 2 cycles after start, rready held low
      arvalid = 1'b1; araddr = 12'h024;
      tick();
      arvalid = 1'b0;
      check("rd_rstart", 32'(bk_rstart), 32'd1);
      check("rd_raddr", 32'(bk_raddr), 32'h024);
      tick();
      check("rd_rstart_pulse", 32'(bk_rstart), 32'd0);
      tick();
      bk_rdone = 1'b1; bk_rdata = 32'h0000_BEEF;
      check("rd_no_early_rvalid", 32'(rvalid), 32'd0);
      tick();
      bk_rdone = 1'b0; bk_rdata = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         check("rd_rvalid_hold", 32'(rvalid), 32'd1);
         check("rd_rdata_hold", rdata, 32'h0000_BEEF);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check("rd_rvalid_drop", 32'(rvalid), 32'd0);
      check("rd_arready_back", 32'(arready), 32'd1);
      check("rd_rdata_kept", rdata, 32'h0000_BEEF);

      // concurrent write 0x004 and read 0x008; read done at earliest cycle
      awvalid = 1'b1; awaddr = 12'h004;
      arvalid = 1'b1; araddr = 12'h008;
      tick();
      awvalid = 1'b0; arvalid = 1'b0;
      wvalid = 1'b1; wdata = 32'h1111_2222; wstrb = 4'h3;
      check("cc_rstart", 32'(bk_rstart), 32'd1);
      check("cc_raddr", 32'(bk_raddr), 32'h008);
      check("cc_wready", 32'(wready), 32'd1);
      tick();
      wvalid = 1'b0;
      check("cc_wstart", 32'(bk_wstart), 32'd1);
      check("cc_waddr", 32'(bk_waddr), 32'h004);
      check("cc_wdata", bk_wdata, 32'h1111_2222);
      check("cc_wstrb", 32'(bk_wstrb), 32'h3);
      bk_rdone = 1'b1; bk_rdata = 32'h5566_7788;
      tick();
      bk_rdone = 1'b0; bk_rdata = '0;
      check("cc_rvalid", 32'(rvalid), 32'd1);
      check("cc_rdata", rdata, 32'h5566_7788);
      check("cc_w_waiting", 32'(awready), 32'd0);
      bk_wdone = 1'b1; rready = 1'b1;
      tick();
      bk_wdone = 1'b0; rready = 1'b0;
      check("cc_both_idle", {30'd0, awready, arready}, 32'd3);
      check("cc_waddr_kept", 32'(bk_waddr), 32'h004);
      check("cc_raddr_kept", 32'(bk_raddr), 32'h008);

      // ordering: W before AW, stray done in W_ADDR, done in start cycle
      wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hC;
      bk_wdone = 1'b1;
      tick();
      bk_wdone = 1'b0;
      check("ord_wready_low", 32'(wready), 32'd0);
      check("ord_stray_done", {30'd0, awready, bk_wstart}, 32'd2);
      tick();
      check("ord_wready_low2", 32'(wready), 32'd0);
      awvalid = 1'b1; awaddr = 12'h0FC;
      tick();
      awvalid = 1'b0;
      check("ord_wready_after_aw", 32'(wready), 32'd1);
      tick();
      wvalid = 1'b0;
      check("ord_wstart", 32'(bk_wstart), 32'd1);
      check("ord_wdata", bk_wdata, 32'hCAFE_F00D);
      check("ord_wstrb", 32'(bk_wstrb), 32'hC);
      check("ord_waddr", 32'(bk_waddr), 32'h0FC);
      bk_wdone = 1'b1;
      tick();
      bk_wdone = 1'b0;
      check("ord_start_done_ignored", 32'(awready), 32'd0);
      tick();
      check("ord_still_waiting", 32'(awready), 32'd0);
      bk_wdone = 1'b1;
      tick();
      bk_wdone = 1'b0;
      check("ord_done", 32'(awready), 32'd1);

      // reset while in R_WAIT
      arvalid = 1'b1; araddr = 12'h040;
      tick();
      arvalid = 1'b0;
      tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_outs", {24'd0, awready, wready, arready, rvalid, bk_wstart, bk_rstart, timeout_err, 1'b0}, 32'd0);
      check("mrst_raddr", 32'(bk_raddr), 32'd0);
      check("mrst_rdata", rdata, 32'd0);
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         cnt += int'(rvalid) + int'(bk_rstart);
      end
      check("mrst_no_resume", 32'(cnt), 32'd0);
      check("mrst_arready", 32'(arready), 32'd1);
      arvalid = 1'b1; araddr = 12'h030;
      tick();
      arvalid = 1'b0;
      check("mrst_rd_raddr", 32'(bk_raddr), 32'h030);
      check("mrst_rd_rstart", 32'(bk_rstart), 32'd1);
      tick();
      bk_rdone = 1'b1; bk_rdata = 32'h3030_3030;
      tick();
      bk_rdone = 1'b0; bk_rdata = '0;
      check("mrst_rd_rdata", rdata, 32'h3030_3030);
      check("mrst_rd_rvalid", 32'(rvalid), 32'd1);
      rready = 1'b1;
      tick();
      rready = 1'b0;

      // read with no backend response
      arvalid = 1'b1; araddr = 12'h050;
      tick();
      arvalid = 1'b0;
`ifdef AXILITE_SLAVE_TIMEOUT_EN
      cnt = 0;
      while (!rvalid && cnt < 100) begin
         tick();
         cnt++;
      end
      check("to_rvalid", 32'(rvalid), 32'd1);
      check("to_rdata", rdata, 32'hDEAD_BEEF);
      check("to_err", 32'(timeout_err), 32'd1);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      tick(); tick();
      check("to_err_sticky", 32'(timeout_err), 32'd1);
      check("to_arready", 32'(arready), 32'd1);
`else
      cnt = 0;
      for (int i = 0; i < 1100; i++) begin
         tick();
         cnt += int'(rvalid) + int'(arready);
      end
      check("nto_still_waiting", 32'(cnt), 32'd0);
      check("nto_err_zero", 32'(timeout_err), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
